sonic_pio_edge_ctrl: RTL
========================

Name: sonic_pio_edge_ctrl

Overview:
- Parametrised successor of the 4-bit Nios PIO input/edge-capture slave: DATA_W-bit input with 2-flop synchroniser, per-bit programmable debounce, configurable edge type, write-1-to-clear capture, and a DATA_W-bit output register with atomic set/clear.
- Sits on the Nios Avalon-MM bus beside the transceiver control logic. Collects board/status inputs, drives control strobes, and raises one level interrupt.

Parameters:
- DATA_W, 4, input/output bit count, 1..32
- EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
- DEB_CNT_W, 16, debounce counter width
- DEB_RESET, 0, reset value of the debounce limit (0 = bypass)
- OUT_RESET, 0, reset value of out_port

Ports:
- clk  in  1  bus/system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  DATA_W  asynchronous inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt
- out_port  out  DATA_W  output register

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous and active-low. All state clears on reset_n low, independent of clk.
- Reset values: readdata=0, irq=0, out_port=OUT_RESET, irq_mask=0, edge_capture=0, sync flops=0, stable=0, all counters=0, deb_limit=DEB_RESET.
- Register map (wr = chipselect & ~write_n):
  - 0 DATA: read returns stable[DATA_W-1:0]. Writes ignored.
  - 1 OUT: read/write out_port.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read. A write clears each bit where writedata=1 (W1C). Bits written 0 are unchanged.
  - 4 OUTSET: write ORs writedata into out_port. Reads as 0.
  - 5 OUTCLR: write ANDs ~writedata into out_port. Reads as 0.
  - 6 DEB_LIMIT: read/write, low DEB_CNT_W bits.
  - 7: reserved. Reads 0, writes ignored.
- Reads:
  - readdata registers the mux of address every clk, with no dependence on chipselect.
  - Latency is 1 cycle.
  - Unused upper bits are 0.
- Synchroniser: s1 <= in_port, s2 <= s1. Two cycles of latency to the raw synchronised value.
- Debounce, per bit, with its own counter:
  - If deb_limit==0: stable <= s2 every cycle.
  - Else, if s2 == stable: cnt <= 0.
  - Else, if cnt == deb_limit-1: stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Result: a change must persist deb_limit consecutive cycles. A glitch shorter than that resets the count and produces no edge.
  - Writing DEB_LIMIT does not reset counters. The new limit applies from the next cycle. If cnt already exceeds the new limit-1, the compare is >= and updates immediately.
- Edge detect: stable_d <= stable. Rise = stable & ~stable_d, fall = ~stable & stable_d, selected by EDGE_TYPE.
- Capture:
  - A detected edge sets edge_capture[i] the next cycle.
  - If a W1C clear of bit i coincides with an edge on bit i, set wins: the bit stays 1.
- irq = |(edge_capture & irq_mask), registered: 1 cycle after capture or mask change. Writing the mask to 0 drops irq the cycle after the write.
- OUT/OUTSET/OUTCLR take effect on out_port the cycle after the write. Only one address is active per write, so there are no conflicts between them.
- Total latency with bypass:
  - in_port change to stable: 3 cycles.
  - in_port change to edge_capture: 4 cycles.
  - in_port change to irq: 5 cycles.

Decomposition:
- Shared package sonic_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_DEB_LIMIT
  - edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY
- One sub-module, sonic_pio_debounce: single-bit synchroniser plus debounce counter (DEB_CNT_W). Instantiated DATA_W times via generate.
- Capture, mask, output and read mux stay in the top level.

Test Plan:
- Reset: hold reset_n low mid-debounce with in_port=4'hF → readdata=0, irq=0, out_port=OUT_RESET. After release, stable rises 3 cycles later (bypass).
- Rising edge, mask=4'b0100, in_port 0→4'b0100 → EDGE_CAPTURE reads 4'b0100 and irq=1 at cycle 5. Write 4'b0100 to addr 3 → irq=0 two cycles later.
- Debounce, DEB_LIMIT=10, bit0: 7-cycle pulse → no capture, DATA stays 0. 12-cycle pulse → DATA bit0=1 exactly 10 cycles after s2 changes, one capture.
- Simultaneous: W1C of bit1 in the same cycle its edge is detected → edge_capture[1] remains 1. W1C with writedata=4'b0010 leaves bit0 set.
- Output: write OUT=4'hA, OUTSET=4'h1, OUTCLR=4'h8 → out_port 4'hA, 4'hB, 4'h3 on successive cycles. Reads of addr 4/5 return 0.
- EDGE_TYPE=2 build: toggle bit3 0→1→0 with a W1C between toggles → two separate captures, irq asserted twice.

Source files
------------

// File: rtl/sonic_pio_pkg.sv
// Shared constants for the sonic PIO edge-capture slave: register word
// addresses and the edge-type encodings used by the EDGE_TYPE parameter.
package sonic_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_OUT       = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
   localparam logic [2:0] ADDR_DEB_LIMIT = 3'd6;
   localparam logic [2:0] ADDR_RSVD      = 3'd7;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sonic_pio_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a
// debounce counter. A change on the synchronised input must persist for
// deb_limit consecutive cycles before it reaches stable; deb_limit == 0
// bypasses the filter so stable follows the synchronised value directly.
module sonic_pio_debounce #(
   parameter int DEB_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_bit,
   input  logic [DEB_CNT_W-1:0] deb_limit,
   output logic                 stable
);

   logic                 s1;
   logic                 s2;
   logic [DEB_CNT_W-1:0] cnt;
   logic [DEB_CNT_W-1:0] limit_m1;

   // Terminal count; compared with >= so that shrinking the limit while a
   // count is in flight commits the pending change on the next cycle.
   assign limit_m1 = deb_limit - DEB_CNT_W'(1);

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= in_bit;
         s2 <= s1;
      end
   end

   // Debounce: count consecutive cycles where s2 differs from stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (deb_limit == '0) begin
         stable <= s2;
         cnt    <= '0;
      end else if (s2 == stable) begin
         cnt <= '0;
      end else if (cnt >= limit_m1) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + DEB_CNT_W'(1);
      end
   end

endmodule

// File: rtl/sonic_pio_edge_ctrl.sv
// Avalon-MM PIO slave: DATA_W debounced inputs with edge capture (W1C),
// interrupt mask and a level irq, plus an output register with atomic
// set/clear aliases. Reads are registered with one cycle of latency and
// do not depend on chipselect.
module sonic_pio_edge_ctrl
   import sonic_pio_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int EDGE_TYPE = 0,
   parameter int DEB_CNT_W = 16,
   parameter int DEB_RESET = 0,
   parameter int OUT_RESET = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [DATA_W-1:0] in_port,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [DATA_W-1:0] out_port
);

   logic                 wr;
   logic [DATA_W-1:0]    stable;
   logic [DATA_W-1:0]    stable_d;
   logic [DATA_W-1:0]    edge_det;
   logic [DATA_W-1:0]    edge_capture;
   logic [DATA_W-1:0]    irq_mask;
   logic [DEB_CNT_W-1:0] deb_limit;
   logic [DATA_W-1:0]    cap_clr;
   logic [31:0]          rd_next;
   logic                 unused_wdata;

   assign wr = chipselect & ~write_n;

   // Upper writedata bits are architecturally ignored for narrow builds.
   assign unused_wdata = ^writedata;

   // One synchroniser/debounce slice per input bit, sharing the limit.
   for (genvar i = 0; i < DATA_W; i++) begin : g_deb
      sonic_pio_debounce #(
         .DEB_CNT_W (DEB_CNT_W)
      ) u_deb (
         .clk       (clk),
         .reset_n   (reset_n),
         .in_bit    (in_port[i]),
         .deb_limit (deb_limit),
         .stable    (stable[i])
      );
   end

   // Delayed copy of the debounced inputs for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d <= '0;
      end else begin
         stable_d <= stable;
      end
   end

   // Select which transitions count as an event.
   always_comb begin
      edge_det = '0;
      if (EDGE_TYPE == EDGE_FALL) begin
         edge_det = ~stable & stable_d;
      end else if (EDGE_TYPE == EDGE_ANY) begin
         edge_det = stable ^ stable_d;
      end else begin
         edge_det = stable & ~stable_d;
      end
   end

   // Bits being cleared by a W1C write this cycle.
   always_comb begin
      cap_clr = '0;
      if (wr && address == ADDR_EDGE_CAP) begin
         cap_clr = writedata[DATA_W-1:0];
      end
   end

   // Edge capture: a new edge wins over a coincident clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= (edge_capture & ~cap_clr) | edge_det;
      end
   end

   // Writable control registers: mask, debounce limit and output port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask  <= '0;
         deb_limit <= DEB_CNT_W'(DEB_RESET);
         out_port  <= DATA_W'(OUT_RESET);
      end else if (wr) begin
         case (address)
            ADDR_OUT:       out_port  <= writedata[DATA_W-1:0];
            ADDR_IRQ_MASK:  irq_mask  <= writedata[DATA_W-1:0];
            ADDR_OUTSET:    out_port  <= out_port | writedata[DATA_W-1:0];
            ADDR_OUTCLR:    out_port  <= out_port & ~writedata[DATA_W-1:0];
            ADDR_DEB_LIMIT: deb_limit <= writedata[DEB_CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // Level interrupt, registered from the current capture and mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(edge_capture & irq_mask);
      end
   end

   // Read mux; unused upper bits and write-only/reserved words read 0.
   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:      rd_next[DATA_W-1:0]    = stable;
         ADDR_OUT:       rd_next[DATA_W-1:0]    = out_port;
         ADDR_IRQ_MASK:  rd_next[DATA_W-1:0]    = irq_mask;
         ADDR_EDGE_CAP:  rd_next[DATA_W-1:0]    = edge_capture;
         ADDR_DEB_LIMIT: rd_next[DEB_CNT_W-1:0] = deb_limit;
         default: ;
      endcase
   end

   // Registered read data, one cycle after the address is presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_next;
      end
   end

endmodule
